// File: rtl/zorro_slave_ctrl.sv
// Zorro III slave-cycle sequencer: qualifies host accesses and drives SLAVE_n, LOCAL_CS_n and DTACK.
// Define ZORRO_MTCR_EN to allow multiple transfers (MTCR_n bursts) under one FCS_n cycle.
module zorro_slave_ctrl #(
    parameter int WAIT_STATES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       FCS_n,
    input  logic [3:0] DS_n,
    input  logic       READ,
    input  logic       DOE,
    input  logic       MATCH,
    input  logic       MYBUS_n,
    input  logic       MTCR_n,
    input  logic       LOCAL_ACK_n,
    output logic       SLAVE_n,
    output logic       LOCAL_CS_n,
    output logic       DTACK_n,
    output logic       DTACK_OE,
    output logic       TIMEOUT_ERR
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [7:0] TO_LOAD   = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        IGNORE,
        SELECT,
        ACCESS,
        ACK,
        RELEASE,
        MWAIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;
    logic [7:0] to_cnt;
    logic [7:0] to_cnt_nxt;
    logic       to_hit;
    logic       to_hit_q;
    logic       strobe;
    logic       access_go;
    logic       ack_ok;
    logic [7:0] to_dec;

    assign strobe    = (DS_n != 4'hF);
    // Reads wait for DOE so the local device only drives once the host has turned the bus.
    assign access_go = strobe && (!READ || DOE);
    assign ack_ok    = (wait_cnt == 4'd0) && !LOCAL_ACK_n;
    assign to_dec    = (to_cnt == 8'd0) ? 8'd0 : to_cnt - 8'd1;

`ifndef ZORRO_MTCR_EN
    logic unused_mtcr;
    assign unused_mtcr = MTCR_n;
`endif

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        to_cnt_nxt   = to_cnt;
        to_hit       = 1'b0;
        case (state)
            IDLE: begin
                if (!FCS_n) begin
                    if (MATCH && MYBUS_n) begin
                        state_nxt  = SELECT;
                        to_cnt_nxt = TO_LOAD;
                    end else begin
                        state_nxt = IGNORE;
                    end
                end
            end
            IGNORE: begin
                if (FCS_n)
                    state_nxt = IDLE;
            end
            SELECT: begin
                to_cnt_nxt = to_dec;
                if (FCS_n) begin
                    state_nxt = IDLE;
                end else if (to_cnt == 8'd0) begin
                    state_nxt = ACK;
                    to_hit    = 1'b1;
                end else if (access_go) begin
                    state_nxt    = ACCESS;
                    wait_cnt_nxt = WAIT_LOAD;
                end
            end
            ACCESS: begin
                to_cnt_nxt = to_dec;
                if (wait_cnt != 4'd0)
                    wait_cnt_nxt = wait_cnt - 4'd1;
                // A real ack on the timeout cycle takes precedence over the forced one.
                if (FCS_n) begin
                    state_nxt = IDLE;
                end else if (ack_ok) begin
                    state_nxt = ACK;
                end else if (to_cnt == 8'd0) begin
                    state_nxt = ACK;
                    to_hit    = 1'b1;
                end
            end
            ACK: begin
                if (FCS_n)
                    state_nxt = RELEASE;
`ifdef ZORRO_MTCR_EN
                else if (!strobe && MTCR_n)
                    state_nxt = MWAIT;
`endif
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
`ifdef ZORRO_MTCR_EN
            MWAIT: begin
                if (FCS_n) begin
                    state_nxt = RELEASE;
                end else if (!MTCR_n && strobe) begin
                    state_nxt    = ACCESS;
                    wait_cnt_nxt = WAIT_LOAD;
                    to_cnt_nxt   = TO_LOAD;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the registered state one clock later, so every pad is glitch-free.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            to_cnt      <= 8'd0;
            to_hit_q    <= 1'b0;
            SLAVE_n     <= 1'b1;
            LOCAL_CS_n  <= 1'b1;
            DTACK_n     <= 1'b1;
            DTACK_OE    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            to_hit_q    <= to_hit;
            SLAVE_n     <= !(state inside {SELECT, ACCESS, ACK, MWAIT});
            LOCAL_CS_n  <= (state != ACCESS);
            DTACK_n     <= (state != ACK);
            DTACK_OE    <= (state inside {ACK, RELEASE, MWAIT});
            TIMEOUT_ERR <= to_hit_q;
        end
    end

endmodule

// File: tb/tb_zorro_slave_ctrl.sv
// Self-checking bench for zorro_slave_ctrl: vector table, directed corner sequences and
// randomized transactions checked against an event-time model of the slave cycle.
module tb_zorro_slave_ctrl;

    localparam int WS = 2;
    localparam int TO = 64;
    localparam logic [4:0] IDLE_O = 5'b11100;  // {SLAVE_n, LOCAL_CS_n, DTACK_n, DTACK_OE, TIMEOUT_ERR}

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic       FCS_n = 1'b1;
    logic [3:0] DS_n = 4'hF;
    logic       READ = 1'b0;
    logic       DOE = 1'b0;
    logic       MATCH = 1'b0;
    logic       MYBUS_n = 1'b1;
    logic       MTCR_n = 1'b1;
    logic       LOCAL_ACK_n = 1'b1;
    logic       SLAVE_n, LOCAL_CS_n, DTACK_n, DTACK_OE, TIMEOUT_ERR;
    logic [4:0] obs;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       fcs_n;
        logic [3:0] ds_n;
        logic       read, doe, match, mybus_n, ack_n;
        logic [4:0] exp;
    } vec_t;
    vec_t vecs[$];

    zorro_slave_ctrl #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .FCS_n(FCS_n), .DS_n(DS_n), .READ(READ), .DOE(DOE),
        .MATCH(MATCH), .MYBUS_n(MYBUS_n), .MTCR_n(MTCR_n), .LOCAL_ACK_n(LOCAL_ACK_n),
        .SLAVE_n(SLAVE_n), .LOCAL_CS_n(LOCAL_CS_n), .DTACK_n(DTACK_n), .DTACK_OE(DTACK_OE),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    assign obs = {SLAVE_n, LOCAL_CS_n, DTACK_n, DTACK_OE, TIMEOUT_ERR};

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b required %b", name, obs, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic void add_vec(input logic f, input logic [3:0] ds, input logic rd,
                                    input logic oe, input logic m, input logic mb,
                                    input logic ak, input logic [4:0] e);
        vec_t v;
        v.fcs_n = f; v.ds_n = ds; v.read = rd; v.doe = oe;
        v.match = m; v.mybus_n = mb; v.ack_n = ak; v.exp = e;
        vecs.push_back(v);
    endfunction

    // One host cycle. Expected outputs come from event edges of the slave cycle:
    // s = edge DS is accepted, e = edge the cycle is acknowledged, r = edge FCS_n rises.
    task automatic run_txn(input int id, input bit hit, input int nh_kind, input int d,
                           input int a, input bit abort_it, input int extra, input bit rd);
        int s, e, r, cs_end;
        bit err;
        logic [3:0] ds_val;
        logic [4:0] exp;
        ds_val = 4'($urandom_range(0, 14));
        s = (d < 2) ? 2 : d;
        err = 1'b0;
        if (s >= TO + 1) begin
            e = TO + 1;
            err = 1'b1;
        end else begin
            e = (s + WS + 1 > a) ? s + WS + 1 : a;
            if (e > TO + 1) begin
                e = TO + 1;
                err = 1'b1;
            end
        end
        if (!hit)          r = 2 + extra % 9;
        else if (abort_it) r = 2 + extra % (e - 1);
        else               r = e + 1 + extra % 4;
        cs_end = abort_it ? r : e;
        for (int t = 1; t <= r + 3; t++) begin
            FCS_n = (t < r) ? 1'b0 : 1'b1;
            DS_n = (t >= d && t < r) ? ds_val : 4'hF;
            READ = rd;
            DOE = rd ? (t >= d) : 1'($urandom_range(0, 1));
            LOCAL_ACK_n = (t >= a && t < r) ? 1'b0 : 1'b1;
            MATCH = hit ? 1'b1 : (nh_kind == 1);
            if (t == 1) MYBUS_n = hit ? 1'b1 : (nh_kind == 0);
            else        MYBUS_n = 1'($urandom_range(0, 1));
            exp[4] = !(hit && t >= 2 && t <= r);
            exp[3] = !(hit && t >= s + 1 && t <= cs_end);
            exp[2] = !(hit && !abort_it && t >= e + 1 && t <= r);
            exp[1] = hit && !abort_it && t >= e + 1 && t <= r + 1;
            exp[0] = hit && !abort_it && err && t == e + 1;
            tick();
            check($sformatf("txn%0d_t%0d", id, t), exp);
        end
    endtask

`ifdef ZORRO_MTCR_EN
    task automatic mtcr_burst();
        int dp, cp, slave_hi, guard;
        logic pd, pc;
        dp = 0; cp = 0; slave_hi = 0; pd = 1'b1; pc = 1'b1;
        FCS_n = 0; MATCH = 1; MYBUS_n = 1; READ = 0; DOE = 0; LOCAL_ACK_n = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            DS_n = 4'h0; MTCR_n = 0; guard = 0;
            do begin
                tick(); guard++;
                if (pd && !DTACK_n) dp++;
                if (pc && !LOCAL_CS_n) cp++;
                if (SLAVE_n) slave_hi++;
                pd = DTACK_n; pc = LOCAL_CS_n;
            end while (DTACK_n !== 1'b0 && guard < 30);
            DS_n = 4'hF; MTCR_n = 1; guard = 0;
            do begin
                tick(); guard++;
                if (pc && !LOCAL_CS_n) cp++;
                if (SLAVE_n) slave_hi++;
                pd = DTACK_n; pc = LOCAL_CS_n;
            end while (DTACK_n !== 1'b1 && guard < 30);
        end
        check_int("mtcr_dtack_pulses", dp, 4);
        check_int("mtcr_cs_pulses", cp, 4);
        check_int("mtcr_slave_gaps", slave_hi, 0);
        FCS_n = 1; LOCAL_ACK_n = 1;
        tick(); tick(); tick();
        check("mtcr_idle", IDLE_O);
    endtask
`endif

    initial begin
        int ts, td, et, errs, found;

        // Plain read with ready ack, then release.
        add_vec(0, 4'h0, 1, 1, 1, 1, 0, 5'b11100);
        add_vec(0, 4'h0, 1, 1, 1, 1, 0, 5'b01100);
        for (int i = 0; i < 3; i++) add_vec(0, 4'h0, 1, 1, 1, 1, 0, 5'b00100);
        for (int i = 0; i < 2; i++) add_vec(0, 4'h0, 1, 1, 1, 1, 0, 5'b01010);
        add_vec(1, 4'hF, 1, 1, 1, 1, 1, 5'b01010);
        add_vec(1, 4'hF, 0, 0, 0, 1, 1, 5'b11110);
        add_vec(1, 4'hF, 0, 0, 0, 1, 1, IDLE_O);
        // Address miss held for 10 clocks.
        for (int i = 0; i < 10; i++) add_vec(0, 4'h0, 0, 0, 0, 1, 0, IDLE_O);
        for (int i = 0; i < 2; i++) add_vec(1, 4'hF, 0, 0, 0, 1, 1, IDLE_O);
        // Board is bus master.
        for (int i = 0; i < 3; i++) add_vec(0, 4'h0, 0, 0, 1, 0, 0, IDLE_O);
        for (int i = 0; i < 2; i++) add_vec(1, 4'hF, 0, 0, 1, 1, 1, IDLE_O);
        // Read waits for DOE, then FCS_n drops out one clock into ACCESS.
        add_vec(0, 4'h0, 1, 0, 1, 1, 0, 5'b11100);
        add_vec(0, 4'h0, 1, 0, 1, 1, 0, 5'b01100);
        add_vec(0, 4'h0, 1, 0, 1, 1, 0, 5'b01100);
        add_vec(0, 4'h0, 1, 1, 1, 1, 1, 5'b01100);
        add_vec(0, 4'h0, 1, 1, 1, 1, 1, 5'b00100);
        add_vec(1, 4'hF, 1, 1, 1, 1, 1, 5'b00100);
        add_vec(1, 4'hF, 0, 0, 0, 1, 1, IDLE_O);
        add_vec(1, 4'hF, 0, 0, 0, 1, 1, IDLE_O);

        tick(); tick();
        check("reset_state", IDLE_O);
        RESET_n = 1;
        tick();
        check("after_reset", IDLE_O);

        foreach (vecs[i]) begin
            FCS_n = vecs[i].fcs_n; DS_n = vecs[i].ds_n; READ = vecs[i].read;
            DOE = vecs[i].doe; MATCH = vecs[i].match; MYBUS_n = vecs[i].mybus_n;
            LOCAL_ACK_n = vecs[i].ack_n;
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Local device never acks: forced DTACK and a single error pulse.
        FCS_n = 0; MATCH = 1; MYBUS_n = 1; DS_n = 4'h0; READ = 0; DOE = 0; LOCAL_ACK_n = 1;
        ts = -1; td = -1; et = -1; errs = 0;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (SLAVE_n === 1'b0 && ts < 0) ts = t;
            if (DTACK_n === 1'b0 && td < 0) td = t;
            if (TIMEOUT_ERR === 1'b1) begin
                errs++;
                if (et < 0) et = t;
            end
        end
        check_int("timeout_seen", (td > 0) ? 1 : 0, 1);
        check_int("timeout_latency", td - ts, TO);
        check_int("timeout_err_align", et, td);
        check_int("timeout_err_width", errs, 1);
        FCS_n = 1; DS_n = 4'hF;
        tick(); tick(); tick();
        check("timeout_idle", IDLE_O);

        // Reset pulsed while acknowledging.
        FCS_n = 0; MATCH = 1; MYBUS_n = 1; DS_n = 4'h0; READ = 1; DOE = 1; LOCAL_ACK_n = 0;
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            tick();
            if (DTACK_n === 1'b0) found = 1;
        end
        check_int("rst_reach_ack", found, 1);
        #2 RESET_n = 0;
        #1 check("rst_async", IDLE_O);
        tick();
        check("rst_held", IDLE_O);
        FCS_n = 1; DS_n = 4'hF; LOCAL_ACK_n = 1; RESET_n = 1;
        tick();
        check("rst_released", IDLE_O);
        run_txn(1000, 1'b1, 0, 1, 1, 1'b0, 2, 1'b1);

        for (int n = 0; n < 40; n++) begin
            run_txn(n, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(1, 6)),
                    ($urandom_range(0, 5) == 0) ? 200 : int'($urandom_range(1, 12)),
                    ($urandom_range(0, 4) == 0), int'($urandom_range(0, 30)),
                    1'($urandom_range(0, 1)));
        end

`ifdef ZORRO_MTCR_EN
        mtcr_burst();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zorro_slave_ctrl.md
Name: zorro_slave_ctrl

Overview:
- Zorro III slave-cycle sequencer placed directly upstream of the transceiver buffer control.
- Qualifies a host access to the board from FCS_n, the address match and the data strobes, then generates the SLAVE_n signal that the buffer control consumes.
- Sequences the local chip select and handshake, and drives DTACK_n back onto the bus with active negation and tri-state.
- Includes a timeout so a hung local device never stalls the host.

Parameters:
WAIT_STATES, 2, minimum CLK cycles LOCAL_CS_n is held low before LOCAL_ACK_n is honoured (legal range 0..15).
TIMEOUT, 64, CLK cycles from entering SELECT until a forced DTACK (legal range 8..255).

Ports:
CLK  input  1  system clock
RESET_n  input  1  reset
FCS_n  input  1  Zorro full-cycle strobe, synchronised upstream
DS_n  input  4  Zorro data strobes, active low
READ  input  1  1 = host read
DOE  input  1  Zorro data output enable
MATCH  input  1  address decode hit, valid while FCS_n is low
MYBUS_n  input  1  low = board is bus master; slave accesses are ignored
MTCR_n  input  1  multiple-transfer strobe; used only under the macro
LOCAL_ACK_n  input  1  local device ready, active low
SLAVE_n  output  1  board selected as slave, active low
LOCAL_CS_n  output  1  local device select, active low
DTACK_n  output  1  registered DTACK level
DTACK_OE  output  1  DTACK pad output enable
TIMEOUT_ERR  output  1  one-cycle pulse when a cycle is force-acknowledged

Behaviour:
- Reset: RESET_n, asynchronous, active-low; clock CLK.
- Values while RESET_n is low: SLAVE_n=1, LOCAL_CS_n=1, DTACK_n=1, DTACK_OE=0, TIMEOUT_ERR=0, state IDLE, counters 0.
- All outputs are registered. All decisions use inputs sampled on the CLK rising edge.
- IDLE:
  - FCS_n=0 && MYBUS_n=1 && MATCH=1 -> SELECT.
  - FCS_n=0 && (MATCH=0 || MYBUS_n=0) -> IGNORE.
- IGNORE: all outputs inactive. Leave to IDLE when FCS_n=1.
- SELECT:
  - SLAVE_n=0, and it stays 0 through ACCESS, ACK and MWAIT.
  - Load the timeout counter with TIMEOUT-1.
  - Advance to ACCESS when DS_n != 4'hF and (READ=0 || DOE=1).
  - Load the wait counter with WAIT_STATES on that transition.
- ACCESS:
  - LOCAL_CS_n=0.
  - Wait counter decrements to 0 and saturates there.
  - Go to ACK when the wait counter is 0 and LOCAL_ACK_n=0.
  - With WAIT_STATES=0, an ack present on the first ACCESS cycle is accepted.
- Timeout:
  - The timeout counter decrements in SELECT and ACCESS.
  - At 0, go to ACK regardless of DS_n/LOCAL_ACK_n, and pulse TIMEOUT_ERR for exactly one cycle.
- ACK:
  - DTACK_OE=1 and DTACK_n=0.
  - LOCAL_CS_n=1 from the first ACK cycle.
  - Hold until FCS_n=1, then go to RELEASE.
- RELEASE:
  - One cycle with DTACK_n=1, DTACK_OE=1 (active negation), and SLAVE_n=1.
  - Then IDLE, with DTACK_OE=0.
- Abort: FCS_n=1 in SELECT or ACCESS -> IDLE next cycle. SLAVE_n=1 and LOCAL_CS_n=1, no DTACK, no error pulse.
- Simultaneous ack and timeout: the ack wins and TIMEOUT_ERR stays 0.
- MYBUS_n is sampled only in IDLE. A change during a slave cycle is ignored.
- Latency figures:
  - FCS_n low to SLAVE_n low: 2 CLK.
  - Ready local ack with WAIT_STATES=2 to DTACK_n low: 4 CLK after DS_n is seen.
- Reset mid-cycle: immediately inactive outputs; DTACK pad released within the reset assertion.

Optional Feature:
ZORRO_MTCR_EN.
- Defined:
  - In ACK, when FCS_n=0 and DS_n=4'hF and MTCR_n=1, go to MWAIT with DTACK_n=1 and DTACK_OE=1.
  - In MWAIT, MTCR_n=0 with DS_n != 4'hF -> ACCESS, reloading the wait counter and the timeout counter. SLAVE_n stays 0.
  - In MWAIT, FCS_n=1 -> RELEASE.
- Undefined: MTCR_n is ignored, MWAIT is unreachable, and each FCS_n cycle carries exactly one transfer.

Test Plan:
1. Read with MATCH=1, DOE=1, DS_n=0, LOCAL_ACK_n=0 and defaults -> SLAVE_n low 2 CLK after FCS_n; LOCAL_CS_n low for 3 CLK; DTACK_n low until FCS_n rises, then 1 CLK high-driven, then DTACK_OE=0.
2. FCS_n low with MATCH=0 for 10 CLK -> SLAVE_n, LOCAL_CS_n and DTACK_OE never assert; returns to IDLE after FCS_n rises.
3. LOCAL_ACK_n held high -> DTACK_n low at SELECT+64 CLK and TIMEOUT_ERR high for exactly 1 CLK.
4. FCS_n deasserted 1 CLK into ACCESS -> LOCAL_CS_n=1 and SLAVE_n=1 next CLK; DTACK_OE never asserts.
5. RESET_n pulsed low during ACK -> DTACK_OE=0 and SLAVE_n=1 while RESET_n is low; a normal cycle completes afterwards.
6. (ZORRO_MTCR_EN) Four MTCR_n/DS_n pulses under one FCS_n -> four DTACK_n low pulses, SLAVE_n continuously low, four LOCAL_CS_n pulses.
